// File: rtl/bus_resolver_n.sv
// Clocked two-state model of a shared multi-driver bus with keeper,
// TRI/TRIAND/TRIOR/PRIORITY resolution and contention bookkeeping.
module bus_resolver_n #(
    parameter int N_DRV = 4,
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic [N_DRV*W-1:0] drv_data,
    input  logic [N_DRV-1:0]   drv_en,
    input  logic               clr,
    output logic [W-1:0]       bus_out,
    output logic [W-1:0]       bus_z,
    output logic [W-1:0]       bus_conf,
    output logic               contention,
    output logic               err_sticky,
    output logic [CNT_W-1:0]   contention_cnt
);

    localparam logic [1:0] M_TRI  = 2'b00;
    localparam logic [1:0] M_AND  = 2'b01;
    localparam logic [1:0] M_OR   = 2'b10;
    localparam logic [1:0] M_PRIO = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               any_en;
    logic               multi_en;
    logic [W-1:0]       and_v;
    logic [W-1:0]       or_v;
    logic [W-1:0]       prio_v;
    logic [W-1:0]       out_n;
    logic [W-1:0]       z_n;
    logic [W-1:0]       conf_n;
    logic               cont_n;

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign any_en   = |drv_en;
    assign multi_en = |(drv_en & (drv_en - 1'b1));

    always_comb begin
        and_v  = '1;
        or_v   = '0;
        prio_v = '0;
        for (int i = 0; i < N_DRV; i++) begin
            if (drv_en[i]) begin
                and_v = and_v & drv_data[i*W +: W];
                or_v  = or_v  | drv_data[i*W +: W];
            end
        end
        // Walk downward so the lowest-index enabled driver is applied last.
        for (int i = N_DRV - 1; i >= 0; i--) begin
            if (drv_en[i]) begin
                prio_v = drv_data[i*W +: W];
            end
        end
    end

    always_comb begin
        out_n  = bus_out;
        z_n    = '1;
        conf_n = '0;
        if (any_en) begin
            z_n = '0;
            unique case (mode)
                M_TRI: begin
                    conf_n = and_v ^ or_v;
                    out_n  = (or_v & ~conf_n) | (bus_out & conf_n);
                end
                M_AND: begin
                    out_n = and_v;
                end
                M_OR: begin
                    out_n = or_v;
                end
                M_PRIO: begin
                    out_n  = prio_v;
                    conf_n = multi_en ? '1 : '0;
                end
                default: begin
                    out_n = bus_out;
                end
            endcase
        end
    end

    assign cont_n = |conf_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_out    <= '0;
            bus_z      <= '1;
            bus_conf   <= '0;
            contention <= 1'b0;
        end else begin
            bus_out    <= out_n;
            bus_z      <= z_n;
            bus_conf   <= conf_n;
            contention <= cont_n;
        end
    end

    // clr beats a same-cycle contention; the contention flag itself is unaffected.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky     <= 1'b0;
            contention_cnt <= '0;
        end else if (clr) begin
            err_sticky     <= 1'b0;
            contention_cnt <= '0;
        end else if (cont_n) begin
            err_sticky <= 1'b1;
            if (contention_cnt != CNT_MAX) begin
                contention_cnt <= contention_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_resolver_n.sv
// Directed self-checking bench for bus_resolver_n (N_DRV=4, W=8, CNT_W=8).
module tb_bus_resolver_n;

    localparam int N_DRV = 4;
    localparam int W     = 8;
    localparam int CNT_W = 8;

    logic               clk;
    logic               rst;
    logic [1:0]         mode;
    logic [N_DRV*W-1:0] drv_data;
    logic [N_DRV-1:0]   drv_en;
    logic               clr;
    logic [W-1:0]       bus_out;
    logic [W-1:0]       bus_z;
    logic [W-1:0]       bus_conf;
    logic               contention;
    logic               err_sticky;
    logic [CNT_W-1:0]   contention_cnt;

    int checks;
    int failures;

    bus_resolver_n #(.N_DRV(N_DRV), .W(W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .mode           (mode),
        .drv_data       (drv_data),
        .drv_en         (drv_en),
        .clr            (clr),
        .bus_out        (bus_out),
        .bus_z          (bus_z),
        .bus_conf       (bus_conf),
        .contention     (contention),
        .err_sticky     (err_sticky),
        .contention_cnt (contention_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_drv(input int i, input logic [W-1:0] v);
        drv_data[i*W +: W] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (bus_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_out got=%h exp=00", bus_out);
        end
        checks++;
        if (bus_z !== 8'hFF || bus_conf !== 8'h00) begin
            failures++;
            $display("FAIL reset_flags got z=%h conf=%h exp z=FF conf=00", bus_z, bus_conf);
        end
        checks++;
        if (contention !== 1'b0 || err_sticky !== 1'b0 || contention_cnt !== 8'h00) begin
            failures++;
            $display("FAIL reset_cnt got c=%b e=%b n=%h exp 0 0 00", contention, err_sticky, contention_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_tri_agree();
        mode   = 2'b00;
        drv_en = 4'b0011;
        set_drv(0, 8'hA5);
        set_drv(1, 8'hA5);
        tick();
        checks++;
        if (bus_out !== 8'hA5) begin
            failures++;
            $display("FAIL tri_agree_out got=%h exp=A5", bus_out);
        end
        checks++;
        if (bus_z !== 8'h00 || bus_conf !== 8'h00 || contention !== 1'b0) begin
            failures++;
            $display("FAIL tri_agree_flags got z=%h conf=%h c=%b exp 00 00 0", bus_z, bus_conf, contention);
        end
    endtask

    task automatic test_tri_conflict();
        set_drv(0, 8'hF0);
        set_drv(1, 8'h0F);
        tick();
        checks++;
        if (bus_out !== 8'hA5 || bus_conf !== 8'hFF) begin
            failures++;
            $display("FAIL tri_conf_out got out=%h conf=%h exp A5 FF", bus_out, bus_conf);
        end
        checks++;
        if (contention !== 1'b1 || err_sticky !== 1'b1 || contention_cnt !== 8'h01) begin
            failures++;
            $display("FAIL tri_conf_flags got c=%b e=%b n=%h exp 1 1 01", contention, err_sticky, contention_cnt);
        end
        drv_en = 4'b0000;
        tick();
        checks++;
        if (bus_out !== 8'hA5 || bus_z !== 8'hFF) begin
            failures++;
            $display("FAIL keeper got out=%h z=%h exp A5 FF", bus_out, bus_z);
        end
        checks++;
        if (contention !== 1'b0 || err_sticky !== 1'b1 || contention_cnt !== 8'h01) begin
            failures++;
            $display("FAIL keeper_flags got c=%b e=%b n=%h exp 0 1 01", contention, err_sticky, contention_cnt);
        end
    endtask

    task automatic test_tri_partial();
        // prior bus A5; bits 2 and 0 disagree and keep A5's bits
        drv_en = 4'b0011;
        set_drv(0, 8'hF0);
        set_drv(1, 8'hF5);
        tick();
        checks++;
        if (bus_out !== 8'hF5 || bus_conf !== 8'h05 || contention !== 1'b1) begin
            failures++;
            $display("FAIL tri_partial got out=%h conf=%h c=%b exp F5 05 1", bus_out, bus_conf, contention);
        end
    endtask

    task automatic test_and_or();
        drv_en = 4'b0111;
        set_drv(0, 8'hF0);
        set_drv(1, 8'h3C);
        set_drv(2, 8'hFF);
        mode = 2'b01;
        tick();
        checks++;
        if (bus_out !== 8'h30 || bus_conf !== 8'h00 || contention !== 1'b0) begin
            failures++;
            $display("FAIL triand got out=%h conf=%h c=%b exp 30 00 0", bus_out, bus_conf, contention);
        end
        mode = 2'b10;
        tick();
        checks++;
        if (bus_out !== 8'hFF || bus_conf !== 8'h00 || bus_z !== 8'h00) begin
            failures++;
            $display("FAIL trior got out=%h conf=%h z=%h exp FF 00 00", bus_out, bus_conf, bus_z);
        end
        mode = 2'b01;
        drv_en = 4'b0010;
        tick();
        checks++;
        if (bus_out !== 8'h3C) begin
            failures++;
            $display("FAIL triand_single got=%h exp=3C", bus_out);
        end
        mode   = 2'b00;
        drv_en = 4'b0000;
        tick();
        checks++;
        if (bus_out !== 8'h3C || bus_z !== 8'hFF) begin
            failures++;
            $display("FAIL mode_keeper got out=%h z=%h exp 3C FF", bus_out, bus_z);
        end
    endtask

    task automatic test_priority();
        mode   = 2'b11;
        drv_en = 4'b1100;
        set_drv(2, 8'h11);
        set_drv(3, 8'h22);
        tick();
        checks++;
        if (bus_out !== 8'h11 || bus_conf !== 8'hFF || contention !== 1'b1) begin
            failures++;
            $display("FAIL prio_two got out=%h conf=%h c=%b exp 11 FF 1", bus_out, bus_conf, contention);
        end
        drv_en = 4'b1000;
        tick();
        checks++;
        if (bus_out !== 8'h22 || bus_conf !== 8'h00 || contention !== 1'b0) begin
            failures++;
            $display("FAIL prio_one got out=%h conf=%h c=%b exp 22 00 0", bus_out, bus_conf, contention);
        end
        // identical data still flags conflict with two drivers
        drv_en = 4'b1010;
        set_drv(1, 8'h22);
        tick();
        checks++;
        if (bus_out !== 8'h22 || bus_conf !== 8'hFF) begin
            failures++;
            $display("FAIL prio_same got out=%h conf=%h exp 22 FF", bus_out, bus_conf);
        end
    endtask

    task automatic test_saturate_clr();
        drv_en = 4'b0000;
        clr    = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (contention_cnt !== 8'h00 || err_sticky !== 1'b0) begin
            failures++;
            $display("FAIL clr_idle got n=%h e=%b exp 00 0", contention_cnt, err_sticky);
        end
        mode   = 2'b00;
        drv_en = 4'b0011;
        set_drv(0, 8'hF0);
        set_drv(1, 8'h0F);
        for (int k = 0; k < 254; k++) tick();
        checks++;
        if (contention_cnt !== 8'hFE) begin
            failures++;
            $display("FAIL cnt_254 got=%h exp=FE", contention_cnt);
        end
        tick();
        checks++;
        if (contention_cnt !== 8'hFF) begin
            failures++;
            $display("FAIL cnt_255 got=%h exp=FF", contention_cnt);
        end
        for (int k = 0; k < 45; k++) tick();
        checks++;
        if (contention_cnt !== 8'hFF || err_sticky !== 1'b1) begin
            failures++;
            $display("FAIL cnt_sat got n=%h e=%b exp FF 1", contention_cnt, err_sticky);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (contention_cnt !== 8'h00 || err_sticky !== 1'b0 || contention !== 1'b1) begin
            failures++;
            $display("FAIL clr_wins got n=%h e=%b c=%b exp 00 0 1", contention_cnt, err_sticky, contention);
        end
        tick();
        checks++;
        if (contention_cnt !== 8'h01 || err_sticky !== 1'b1) begin
            failures++;
            $display("FAIL after_clr got n=%h e=%b exp 01 1", contention_cnt, err_sticky);
        end
    endtask

    task automatic test_reset_mid();
        mode   = 2'b10;
        drv_en = 4'b0001;
        set_drv(0, 8'h5A);
        tick();
        mode   = 2'b00;
        drv_en = 4'b0011;
        set_drv(0, 8'hF0);
        set_drv(1, 8'h0F);
        rst = 1'b1;
        clr = 1'b0;
        tick();
        checks++;
        if (bus_out !== 8'h00 || bus_z !== 8'hFF || bus_conf !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_bus got out=%h z=%h conf=%h exp 00 FF 00", bus_out, bus_z, bus_conf);
        end
        checks++;
        if (contention !== 1'b0 || err_sticky !== 1'b0 || contention_cnt !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_flags got c=%b e=%b n=%h exp 0 0 00", contention, err_sticky, contention_cnt);
        end
        rst    = 1'b0;
        drv_en = 4'b0000;
        tick();
        checks++;
        if (bus_out !== 8'h00 || bus_z !== 8'hFF) begin
            failures++;
            $display("FAIL rst_keeper got out=%h z=%h exp 00 FF", bus_out, bus_z);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clr      = 1'b0;
        mode     = 2'b00;
        drv_en   = '0;
        drv_data = '0;
        @(negedge clk);
        test_reset();
        test_tri_agree();
        test_tri_conflict();
        test_tri_partial();
        test_and_or();
        test_priority();
        test_saturate_clr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
